// File: rtl/irq_pkg.sv
// Shared constants for the J1 IO-mapped interrupt controller: register offsets and default base.
package irq_pkg;

  localparam logic [15:0] IRQ_BASE_DEFAULT = 16'h0040;

  typedef enum logic [2:0] {
    IRQ_OFS_PENDING = 3'd0,
    IRQ_OFS_ENABLE  = 3'd1,
    IRQ_OFS_EDGE    = 3'd2,
    IRQ_OFS_FORCE   = 3'd3,
    IRQ_OFS_VECTOR  = 3'd4
  } irq_ofs_e;

endpackage

// File: rtl/prio_onehot8.sv
// Highest-index-wins priority picker: one-hot of the top set bit, its index, and a valid flag.
module prio_onehot8 (
  input  logic [7:0] req,
  output logic [7:0] onehot,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    // Ascending scan so the last hit, i.e. the highest index, wins.
    for (int unsigned i = 0; i < 8; i++) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = 3'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: syncs 8 event lines, latches pending (edge/level), masks, and drives a
// registered one-hot request to the CPU; software access via IO-mapped registers.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = IRQ_BASE_DEFAULT,
  parameter int          NSRC      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  input  logic [7:0]  src,
  output logic [7:0]  int_rqst
);

  if (NSRC != 8) begin : g_nsrc_check
    $error("irq_ctrl supports exactly 8 sources");
  end

  logic [7:0]  s1, s2, s3;
  logic [7:0]  pending, enable, edge_mode;
  logic        sel, wr_hit, rd_hit;
  logic [2:0]  ofs;
  logic [7:0]  clr, frc, pend_nxt, active;
  logic [7:0]  top_onehot;
  logic [2:0]  top_idx;
  logic        top_valid;
  logic [15:0] rdata_nxt;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^io_wdata[15:8];

  assign sel    = (io_addr[15:3] == BASE_ADDR[15:3]);
  assign ofs    = io_addr[2:0];
  assign wr_hit = io_wr & sel;
  assign rd_hit = io_rd & sel;
  assign active = pending & enable;

  prio_onehot8 u_prio (
    .req    (active),
    .onehot (top_onehot),
    .idx    (top_idx),
    .valid  (top_valid)
  );

  always_comb begin
    clr = '0;
    frc = '0;
    if (wr_hit && ofs == IRQ_OFS_PENDING) clr = io_wdata[7:0];
    if (wr_hit && ofs == IRQ_OFS_FORCE)   frc = io_wdata[7:0];
    // Edge lanes: set (rise or force) overrides W1C; level lanes track the synced line.
    pend_nxt = (edge_mode & ((pending & ~clr) | (s2 & ~s3) | frc))
             | (~edge_mode & (s2 | frc));
  end

  always_comb begin
    rdata_nxt = '0;
    case (ofs)
      IRQ_OFS_PENDING: rdata_nxt = {8'h00, pending};
      IRQ_OFS_ENABLE:  rdata_nxt = {8'h00, enable};
      IRQ_OFS_EDGE:    rdata_nxt = {8'h00, edge_mode};
      IRQ_OFS_FORCE:   rdata_nxt = {8'h00, s2};
      IRQ_OFS_VECTOR:  rdata_nxt = {top_valid, 12'h000, top_idx};
      default:         rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      io_rdata  <= '0;
      int_rqst  <= '0;
    end else begin
      s1       <= src;
      s2       <= s1;
      s3       <= s2;
      pending  <= pend_nxt;
      int_rqst <= top_onehot;
      if (wr_hit && ofs == IRQ_OFS_ENABLE) enable    <= io_wdata[7:0];
      if (wr_hit && ofs == IRQ_OFS_EDGE)   edge_mode <= io_wdata[7:0];
      if (rd_hit)                          io_rdata  <= rdata_nxt;
    end
  end

  a_rqst_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(int_rqst));

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the register/pending rules.
module tb_irq_ctrl;

  localparam logic [15:0] BASE = 16'h0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = '0;
  logic [15:0] io_wdata = '0;
  logic [15:0] io_rdata;
  logic [7:0]  src = '0;
  logic [7:0]  int_rqst;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0]  m_pend = '0, m_en = '0, m_edge = '0, m_rqst = '0;
  logic [15:0] m_rdata = '0;
  logic [7:0]  hist[$] = '{8'h00, 8'h00, 8'h00}; // [0]=oldest sample (s3), [1]=s2, [2]=s1

  irq_ctrl #(.BASE_ADDR(BASE), .NSRC(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .src      (src),
    .int_rqst (int_rqst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int top_index(input logic [7:0] v);
    int k = -1;
    for (int i = 0; i < 8; i++) if (v[i]) k = i;
    return k;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [7:0] np;
    logic [7:0] s2m, s3m;
    logic       dec, wrhit, frc, clr;
    int         ofs, k;
    if (reset) begin
      m_pend = '0; m_en = '0; m_edge = '0; m_rqst = '0; m_rdata = '0;
      hist = '{8'h00, 8'h00, 8'h00};
      return;
    end
    s2m   = hist[1];
    s3m   = hist[0];
    dec   = (int'(io_addr) / 8) == (int'(BASE) / 8);
    ofs   = int'(io_addr) % 8;
    wrhit = io_wr && dec;
    k     = top_index(m_pend & m_en);
    if (io_rd && dec) begin
      case (ofs)
        0: m_rdata = {8'h00, m_pend};
        1: m_rdata = {8'h00, m_en};
        2: m_rdata = {8'h00, m_edge};
        3: m_rdata = {8'h00, s2m};
        4: m_rdata = (k < 0) ? 16'h0000 : 16'(32768 + k);
        default: m_rdata = 16'h0000;
      endcase
    end
    m_rqst = (k < 0) ? 8'h00 : 8'(1 << k);
    for (int i = 0; i < 8; i++) begin
      frc = wrhit && ofs == 3 && io_wdata[i];
      clr = wrhit && ofs == 0 && io_wdata[i];
      if (!m_edge[i])                       np[i] = s2m[i] || frc;
      else if ((s2m[i] && !s3m[i]) || frc)  np[i] = 1'b1;
      else if (clr)                         np[i] = 1'b0;
      else                                  np[i] = m_pend[i];
    end
    if (wrhit && ofs == 1) m_en   = io_wdata[7:0];
    if (wrhit && ofs == 2) m_edge = io_wdata[7:0];
    m_pend = np;
    hist.push_back(src);
    void'(hist.pop_front());
  endtask

  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [15:0] wdata);
    reset = rst; io_rd = rd; io_wr = wr; io_addr = addr; io_wdata = wdata;
    @(posedge clk);
    model_edge();
    #1;
    check("int_rqst", {8'h00, int_rqst}, {8'h00, m_rqst});
    check("io_rdata", io_rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask
  task automatic wr_reg(input logic [15:0] addr, input logic [15:0] data);
    step(1'b0, 1'b0, 1'b1, addr, data);
  endtask
  task automatic rd_reg(input logic [15:0] addr);
    step(1'b0, 1'b1, 1'b0, addr, 16'h0000);
  endtask

  initial begin
    // Reset
    src = 8'h00;
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("reset_rqst", {8'h00, int_rqst}, 16'h0000);
    check("reset_rdata", io_rdata, 16'h0000);

    // 1: edge-mode source 0, latency, VECTOR, W1C, no re-trigger while held high
    wr_reg(BASE + 16'd1, 16'h0001);
    wr_reg(BASE + 16'd2, 16'h0001);
    idle(2);
    src = 8'h01;
    idle(3);
    check("t1_rqst_before", {8'h00, int_rqst}, 16'h0000);
    idle(1);
    check("t1_rqst_3rd", {8'h00, int_rqst}, 16'h0001);
    rd_reg(BASE + 16'd4);
    check("t1_vector", io_rdata, 16'h8000);
    wr_reg(BASE + 16'd0, 16'h0001);
    idle(1);
    check("t1_w1c_drop", {8'h00, int_rqst}, 16'h0000);
    idle(5);
    check("t1_no_retrig", {8'h00, int_rqst}, 16'h0000);

    // 2: two sources at once, priority, clear of the top one
    src = 8'h00;
    idle(3);
    wr_reg(BASE + 16'd1, 16'h00FF);
    wr_reg(BASE + 16'd2, 16'h00FF);
    wr_reg(BASE + 16'd0, 16'h00FF);
    src = 8'h44;
    idle(4);
    check("t2_rqst_hi", {8'h00, int_rqst}, 16'h0040);
    rd_reg(BASE + 16'd4);
    check("t2_vector", io_rdata, 16'h8006);
    wr_reg(BASE + 16'd0, 16'h0040);
    check("t2_rqst_hold", {8'h00, int_rqst}, 16'h0040);
    idle(1);
    check("t2_rqst_next", {8'h00, int_rqst}, 16'h0004);

    // 3: level mode bit 3, W1C ineffective while high, falls after the line drops
    src = 8'h00;
    idle(3);
    wr_reg(BASE + 16'd0, 16'h00FF);
    wr_reg(BASE + 16'd1, 16'h0008);
    wr_reg(BASE + 16'd2, 16'h0000);
    src = 8'h08;
    idle(3);
    wr_reg(BASE + 16'd0, 16'h0008);
    rd_reg(BASE + 16'd0);
    check("t3_level_hold", io_rdata, 16'h0008);
    check("t3_rqst", {8'h00, int_rqst}, 16'h0008);
    src = 8'h00;
    idle(3);
    rd_reg(BASE + 16'd0);
    check("t3_level_fall", io_rdata, 16'h0000);

    // 4: edge on bit 5 coincides with W1C of bit 5
    wr_reg(BASE + 16'd2, 16'h0020);
    idle(2);
    src = 8'h20;
    idle(2);
    wr_reg(BASE + 16'd0, 16'h0020);
    rd_reg(BASE + 16'd0);
    check("t4_set_beats_clr", io_rdata, 16'h0020);

    // 5: force with mask off, then enable, then reset mid-request
    src = 8'h00;
    wr_reg(BASE + 16'd1, 16'h0000);
    wr_reg(BASE + 16'd2, 16'h00FF);
    wr_reg(BASE + 16'd0, 16'h00FF);
    idle(3);
    wr_reg(BASE + 16'd3, 16'h0080);
    rd_reg(BASE + 16'd0);
    check("t5_forced", io_rdata, 16'h0080);
    check("t5_masked", {8'h00, int_rqst}, 16'h0000);
    wr_reg(BASE + 16'd1, 16'h0080);
    idle(1);
    check("t5_rqst", {8'h00, int_rqst}, 16'h0080);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("t5_reset_rqst", {8'h00, int_rqst}, 16'h0000);
    for (int o = 0; o < 5; o++) begin
      rd_reg(BASE + 16'(o));
      check("t5_reset_reg", io_rdata, 16'h0000);
    end

    // 6: unmapped offset, foreign base write, undecoded read holds
    wr_reg(BASE + 16'd1, 16'h005A);
    rd_reg(BASE + 16'd1);
    check("t6_enable", io_rdata, 16'h005A);
    rd_reg(BASE + 16'd6);
    check("t6_ofs6", io_rdata, 16'h0000);
    wr_reg(16'h0081, 16'h00FF);
    rd_reg(BASE + 16'd1);
    check("t6_foreign_wr", io_rdata, 16'h005A);
    rd_reg(16'h0141);
    check("t6_undecoded_hold", io_rdata, 16'h005A);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        r, w, rs;
      logic [15:0] a;
      if ($urandom_range(3, 0) == 0) src = src ^ 8'($urandom);
      r  = ($urandom_range(9, 0) < 3);
      w  = ($urandom_range(9, 0) < 3);
      rs = ($urandom_range(299, 0) == 0);
      if ($urandom_range(9, 0) < 8) a = BASE + 16'($urandom_range(7, 0));
      else                          a = 16'($urandom);
      step(rs, r, w, a, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
